// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the single-port data RAM between the CPU dmem port and a
//            burst requester. The CPU wins every contested cycle; a starvation
//            counter forces one burst slot after MAX_WAIT consecutive losses.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic              CLK,
  input  logic              CPU_RESETN,
  // CPU port
  input  logic              cpu_valid,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  // burst requester port
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [LEN_W-1:0]  dma_len,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_wready,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              dma_busy,
  output logic              dma_done,
  // RAM port
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  // Wait counter is sized for the largest legal MAX_WAIT (255).
  localparam int          WAIT_W     = 8;
  localparam [WAIT_W-1:0] c_wait_max = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                dir_q, dir_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                rvalid_q, rvalid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dma_slot;

  // Slot decision and RAM port mux: the burst only owns the RAM when the CPU
  // is idle or the CPU has starved the burst for MAX_WAIT cycles in a row.
  always_comb begin
    dma_slot   = (state_q == S_BURST) && (!cpu_valid || (wait_q == c_wait_max));
    cpu_stall  = cpu_valid && dma_slot;
    dma_wready = dma_slot && dir_q;
    if (dma_slot) begin
      ram_addr  = ptr_q;
      ram_wen   = dir_q;
      ram_wdata = dma_wdata;
    end else begin
      ram_addr  = cpu_addr;
      ram_wen   = cpu_valid && cpu_wen;
      ram_wdata = cpu_wdata;
    end
    cpu_rdata  = ram_rdata;
    dma_rdata  = ram_rdata;
    dma_rvalid = rvalid_q;
    dma_busy   = busy_q;
    dma_done   = done_q;
  end

  // Next-state logic for the burst sequencer, pointer, count and wait counter.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (dma_req) begin
          state_d = S_BURST;
          dir_d   = dma_we;
          ptr_d   = dma_addr;
          rem_d   = dma_len;
        end
      end
      S_BURST: begin
        if (dma_slot) begin
          // Pointer wraps naturally at the top of the address space.
          ptr_d  = ptr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          wait_d = '0;
          if (rem_q == '0) begin
            state_d = S_DRAIN;
          end
        end else if (cpu_valid && (wait_q != c_wait_max)) begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // One cycle lets the last read word return alongside dma_done.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Status outputs are registered so they are clean decodes of the new state.
    rvalid_d = dma_slot && !dir_q;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DRAIN);
  end

  // State registers; reset abandons any burst in flight.
  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q  <= S_IDLE;
      dir_q    <= 1'b0;
      ptr_q    <= '0;
      rem_q    <= '0;
      wait_q   <= '0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      wait_q   <= wait_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed bench for dmem_arbiter with a behavioural synchronous
//            RAM. Expected RAM writes, burst read words and CPU read data are
//            queued by the stimulus and checked by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int LEN_W    = 4;
  localparam int MAX_WAIT = 8;

  logic              CLK = 1'b0;
  logic              CPU_RESETN = 1'b0;
  logic              cpu_valid = 1'b0;
  logic              cpu_wen = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dma_req = 1'b0;
  logic              dma_we = 1'b0;
  logic [ADDR_W-1:0] dma_addr = '0;
  logic [LEN_W-1:0]  dma_len = '0;
  logic [DATA_W-1:0] dma_wdata = '0;
  logic              dma_wready;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;
  logic              dma_busy;
  logic              dma_done;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .CLK(CLK), .CPU_RESETN(CPU_RESETN),
    .cpu_valid(cpu_valid), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_wready(dma_wready), .dma_rdata(dma_rdata),
    .dma_rvalid(dma_rvalid), .dma_busy(dma_busy), .dma_done(dma_done),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 CLK = ~CLK;

  // Behavioural single-port RAM with synchronous read.
  logic [DATA_W-1:0] mem [0:4095];
  always @(posedge CLK) begin
    if (ram_wen) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               exp_wr[$];
  logic [DATA_W:0]   exp_rd[$];   // {last, data}
  logic [DATA_W-1:0] exp_cpu[$];
  int                checks = 0;
  int                failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every RAM write, burst read return and CPU read return is popped
  // against the expectation queues.
  wr_t             mon_wr;
  logic [DATA_W:0] mon_rd;
  logic            cpu_rd_pend = 1'b0;
  always @(negedge CLK) begin
    if (ram_wen) begin
      if (exp_wr.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", ram_addr, ram_wdata);
      end else begin
        mon_wr = exp_wr.pop_front();
        check("wr_addr", 32'(ram_addr), 32'(mon_wr.addr));
        check("wr_data", ram_wdata, mon_wr.data);
      end
    end
    if (dma_rvalid) begin
      if (exp_rd.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rvalid: got data %h expected no rvalid", dma_rdata);
      end else begin
        mon_rd = exp_rd.pop_front();
        check("rd_data", dma_rdata, mon_rd[DATA_W-1:0]);
        check("rd_last_done", 32'(dma_done), 32'(mon_rd[DATA_W]));
      end
    end
    if (cpu_rd_pend) begin
      if (exp_cpu.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_cpu_read: got %h expected no read", cpu_rdata);
      end else begin
        check("cpu_rdata", cpu_rdata, exp_cpu.pop_front());
      end
    end
    cpu_rd_pend = CPU_RESETN && cpu_valid && !cpu_wen && !cpu_stall;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cpu_valid = 1'b1; cpu_wen = 1'b1; cpu_addr = a; cpu_wdata = d;
    exp_wr.push_back({a, d});
    @(negedge CLK);
    check("cpu_wr_stall", 32'(cpu_stall), 32'd0);
    step();
    cpu_valid = 1'b0; cpu_wen = 1'b0;
  endtask

  task automatic cpu_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cpu_valid = 1'b1; cpu_wen = 1'b0; cpu_addr = a;
    exp_cpu.push_back(d);
    @(negedge CLK);
    check("cpu_rd_stall", 32'(cpu_stall), 32'd0);
    step();
    cpu_valid = 1'b0;
  endtask

  logic [ADDR_W-1:0] t3_addr [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
  logic [DATA_W-1:0] t3_data [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
  logic [DATA_W-1:0] t5_data [3] = '{32'h55, 32'h66, 32'h77};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int idx;
    int n;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy", 32'(dma_busy), 32'd0);
    check("rst_done", 32'(dma_done), 32'd0);
    check("rst_rvalid", 32'(dma_rvalid), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_ram_wen", 32'(ram_wen), 32'd0);
    check("rst_wready", 32'(dma_wready), 32'd0);
    step();
    CPU_RESETN = 1'b1;
    step();

    // 1: CPU write then read back
    cpu_write(12'h010, 32'hDEAD_BEEF);
    cpu_read(12'h010, 32'hDEAD_BEEF);

    // 2: DMA write burst 0x100..0x103, data 1..4, CPU idle
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 12'h100; dma_len = 4'd3; dma_wdata = 32'd1;
    for (int i = 0; i < 4; i++) exp_wr.push_back({12'(12'h100 + i), 32'(i + 1)});
    @(negedge CLK);
    check("t2_busy_idle", 32'(dma_busy), 32'd0);
    step();
    dma_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("t2_wready", 32'(dma_wready), 32'd1);
      check("t2_busy", 32'(dma_busy), 32'd1);
      check("t2_done_early", 32'(dma_done), 32'd0);
      step();
      dma_wdata = 32'(i + 2);
    end
    @(negedge CLK);
    check("t2_done", 32'(dma_done), 32'd1);
    check("t2_drain_wready", 32'(dma_wready), 32'd0);
    step();
    @(negedge CLK);
    check("t2_done_clear", 32'(dma_done), 32'd0);
    check("t2_busy_clear", 32'(dma_busy), 32'd0);
    step();
    for (int i = 0; i < 4; i++) cpu_read(12'(12'h100 + i), 32'(i + 1));

    // 3: DMA read burst wrapping 0xFFE -> 0x001
    for (int i = 0; i < 4; i++) cpu_write(t3_addr[i], t3_data[i]);
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 12'hFFE; dma_len = 4'd3;
    step();
    dma_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_rd.push_back({(i == 3), t3_data[i]});
      @(negedge CLK);
      check("t3_addr", 32'(ram_addr), 32'(t3_addr[i]));
      check("t3_ram_wen", 32'(ram_wen), 32'd0);
      step();
    end
    @(negedge CLK);
    check("t3_done", 32'(dma_done), 32'd1);
    check("t3_rvalid_last", 32'(dma_rvalid), 32'd1);
    step();

    // 4: CPU busy every cycle, starvation forces the slot after MAX_WAIT
    cpu_valid = 1'b1; cpu_wen = 1'b0; cpu_addr = 12'h100;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 12'h102; dma_len = 4'd0;
    exp_cpu.push_back(32'd1);
    @(negedge CLK);
    check("t4_stall_idle", 32'(cpu_stall), 32'd0);
    step();
    dma_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_cpu.push_back(32'd1);
      @(negedge CLK);
      check("t4_stall_served", 32'(cpu_stall), 32'd0);
      check("t4_addr_cpu", 32'(ram_addr), 32'h100);
      step();
    end
    exp_rd.push_back({1'b1, 32'd3});
    @(negedge CLK);
    check("t4_stall_forced", 32'(cpu_stall), 32'd1);
    check("t4_addr_dma", 32'(ram_addr), 32'h102);
    check("t4_ram_wen", 32'(ram_wen), 32'd0);
    step();
    exp_cpu.push_back(32'd1);
    @(negedge CLK);
    check("t4_stall_after", 32'(cpu_stall), 32'd0);
    check("t4_done", 32'(dma_done), 32'd1);
    check("t4_rvalid", 32'(dma_rvalid), 32'd1);
    step();
    cpu_valid = 1'b0;

    // 5: alternating CPU activity during a 3-word write burst
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 12'h200; dma_len = 4'd2; dma_wdata = t5_data[0];
    for (int i = 0; i < 3; i++) exp_wr.push_back({12'(12'h200 + i), t5_data[i]});
    step();
    dma_req = 1'b0;
    idx = 0;
    n = 0;
    while (idx < 3 && n < 20) begin
      cpu_valid = (n % 2 == 0); cpu_wen = 1'b0; cpu_addr = 12'h100;
      if (cpu_valid) exp_cpu.push_back(32'd1);
      @(negedge CLK);
      check("t5_stall", 32'(cpu_stall), 32'd0);
      check("t5_wready", 32'(dma_wready), 32'(!cpu_valid));
      if (dma_wready) idx++;
      step();
      if (idx < 3) dma_wdata = t5_data[idx];
      n++;
    end
    check("t5_words", 32'(idx), 32'd3);
    check("t5_cycles", 32'(n), 32'd6);
    cpu_valid = 1'b0;
    @(negedge CLK);
    check("t5_done", 32'(dma_done), 32'd1);
    step();

    // 6: reset in the middle of an 8-word write burst
    for (int i = 2; i < 8; i++) cpu_write(12'(12'h300 + i), 32'hEE00_0000 | 32'(i));
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 12'h300; dma_len = 4'd7; dma_wdata = 32'hC0;
    exp_wr.push_back({12'h300, 32'hC0});
    exp_wr.push_back({12'h301, 32'hC1});
    step();
    dma_req = 1'b0;
    @(negedge CLK);
    check("t6_wready0", 32'(dma_wready), 32'd1);
    step();
    dma_wdata = 32'hC1;
    @(negedge CLK);
    check("t6_wready1", 32'(dma_wready), 32'd1);
    step();
    dma_wdata = 32'hC2;
    CPU_RESETN = 1'b0;
    #1;
    check("t6_busy_async", 32'(dma_busy), 32'd0);
    check("t6_wen_async", 32'(ram_wen), 32'd0);
    @(negedge CLK);
    check("t6_stall_rst", 32'(cpu_stall), 32'd0);
    step();
    CPU_RESETN = 1'b1;
    @(negedge CLK);
    check("t6_busy_post", 32'(dma_busy), 32'd0);
    check("t6_wen_post", 32'(ram_wen), 32'd0);
    step();
    cpu_read(12'h300, 32'hC0);
    cpu_read(12'h301, 32'hC1);
    for (int i = 2; i < 8; i++) cpu_read(12'(12'h300 + i), 32'hEE00_0000 | 32'(i));
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 12'h308; dma_len = 4'd0; dma_wdata = 32'h99;
    exp_wr.push_back({12'h308, 32'h99});
    step();
    dma_req = 1'b0;
    @(negedge CLK);
    check("t6_new_busy", 32'(dma_busy), 32'd1);
    check("t6_new_wready", 32'(dma_wready), 32'd1);
    step();
    @(negedge CLK);
    check("t6_new_done", 32'(dma_done), 32'd1);
    step();
    cpu_read(12'h308, 32'h99);

    // Drain and confirm every expectation was consumed
    repeat (3) step();
    check("sb_wr_empty", 32'(exp_wr.size()), 32'd0);
    check("sb_rd_empty", 32'(exp_rd.size()), 32'd0);
    check("sb_cpu_empty", 32'(exp_cpu.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM (12-bit word address, 32-bit data, synchronous read) between the processor's dmem port and a burst requester (sonar echo-capture engine).
- CPU has priority every cycle. The burst requester gets free slots.
- A starvation counter forces a burst slot, stalling the CPU, after MAX_WAIT consecutive lost cycles.
- Sits between the processor/capture engine and the RAM instance in the top-level wrapper.

Parameters:
- ADDR_W, 12, RAM word-address width.
- DATA_W, 32, data width.
- LEN_W, 4, burst-length field width; a burst is dma_len+1 words (1..16).
- MAX_WAIT, 8, consecutive lost cycles before a burst slot is forced (range 1..255).

Ports:
- CLK  in  1  clock; all state on posedge.
- CPU_RESETN  in  1  asynchronous active-low reset.
- cpu_valid  in  1  CPU accesses RAM this cycle.
- cpu_wen  in  1  CPU write enable (qualified by cpu_valid).
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  read data, equal to ram_rdata.
- cpu_stall  out  1  CPU must hold its access and not advance.
- dma_req  in  1  burst request, sampled in IDLE only.
- dma_we  in  1  burst direction (1 = write), sampled with dma_req.
- dma_addr  in  ADDR_W  burst start address, sampled with dma_req.
- dma_len  in  LEN_W  words minus one, sampled with dma_req.
- dma_wdata  in  DATA_W  current write word.
- dma_wready  out  1  current write word consumed this cycle; requester advances.
- dma_rdata  out  DATA_W  read word.
- dma_rvalid  out  1  dma_rdata valid.
- dma_busy  out  1  burst in progress (state != IDLE).
- dma_done  out  1  one-cycle pulse at burst end.
- ram_wen  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after the address is presented.

Behaviour:
- States: IDLE, BURST, DRAIN.
  - IDLE -> BURST when dma_req=1. Latch dir, addr pointer and remaining count (= dma_len). Clear wait counter.
  - BURST -> DRAIN when the last word (remaining=0) is issued.
  - DRAIN -> IDLE unconditionally after one cycle. dma_done=1 in the DRAIN cycle.
- Slot decision each cycle (combinational):
  - dma_slot = (state==BURST) && (!cpu_valid || wait==MAX_WAIT).
  - cpu_stall = cpu_valid && dma_slot.
- Port mux:
  - dma_slot=1: ram_addr=pointer, ram_wen=latched dir, ram_wdata=dma_wdata.
  - otherwise: ram_addr=cpu_addr, ram_wen=cpu_valid&cpu_wen, ram_wdata=cpu_wdata.
  - ram_wen=0 when neither side is valid.
- On a DMA issue:
  - pointer += 1, wrapping 4095 -> 0.
  - remaining -= 1.
  - wait <- 0.
  - dma_wready = dma_slot & dir (combinational).
- Wait counter:
  - In BURST with cpu_valid=1 and dma_slot=0: wait += 1, saturating at MAX_WAIT.
  - Cleared in IDLE and on every DMA issue.
- Read return:
  - dma_rvalid is registered: 1 the cycle after a DMA read issue.
  - dma_rdata = ram_rdata.
  - The last read word's dma_rvalid coincides with the DRAIN cycle, so it arrives together with dma_done.
- Write bursts: dma_rvalid stays 0. dma_done still comes in DRAIN, one cycle after the last write issue.
- cpu_rdata is always ram_rdata. The CPU must only consume it the cycle after its own unstalled read.
- dma_req while busy is ignored. A request held high in DRAIN starts a new burst on the cycle after IDLE is entered.
- Reset (asynchronous, any state, including mid-burst):
  - state=IDLE; wait, pointer, remaining=0.
  - dma_rvalid, dma_done, dma_busy=0.
  - The partial burst is abandoned; no further RAM writes are issued.
  - Combinational outputs follow the CPU path.

Test Plan:
1. Reset, then CPU write 0xDEADBEEF @0x010, next cycle read @0x010 -> ram_wen pulse; cpu_rdata=0xDEADBEEF one cycle after the read; cpu_stall=0 throughout.
2. CPU idle, DMA write burst addr=0x100, len=3, data 1..4 -> four consecutive ram_wen cycles at 0x100..0x103, dma_wready=1 each; dma_done one cycle after the 4th; RAM holds 1..4.
3. DMA read burst addr=0xFFE, len=3, CPU idle -> addresses 0xFFE, 0xFFF, 0x000, 0x001; dma_rvalid on 4 consecutive cycles, each one cycle after its issue; the last coincides with dma_done.
4. cpu_valid held 1 continuously, DMA read len=0, MAX_WAIT=8 -> CPU served 8 cycles; 9th cycle cpu_stall=1 and RAM sees the DMA address; next cycle dma_rvalid=1 and dma_done=1; cpu_stall=0 again.
5. Alternating cpu_valid 1/0 during a DMA write len=2 -> DMA words issued only in the CPU-idle cycles; cpu_stall never asserted; wait counter never exceeds 1.
6. CPU_RESETN pulsed low after 2 of 8 DMA write words -> dma_busy falls immediately; no further DMA writes to RAM; words 3..8 untouched; a new dma_req after release is accepted normally.
